// File: rtl/fir_pkg.sv
// Shared FIR definitions: sequencer state encoding and the output-width rule
// that every FIR variant uses so their result buses agree.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  function automatic int fir_width_y(input int width_x, input int width_b, input int n);
    return width_x + width_b + n + 1;
  endfunction

endpackage

// File: rtl/fir_coef_rf.sv
// (N+1) x WIDTH_B coefficient register file: one gated write port,
// one combinational read port driven by the tap counter.
module fir_coef_rf #(
  parameter  int N       = 5,
  parameter  int WIDTH_B = 3,
  localparam int WIDTH_A = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      we,
  input  logic [WIDTH_A-1:0]        waddr,
  input  logic signed [WIDTH_B-1:0] wdata,
  input  logic [WIDTH_A-1:0]        raddr,
  output logic signed [WIDTH_B-1:0] rdata
);

  localparam logic [WIDTH_A-1:0] ADDR_MAX = WIDTH_A'(N);

  logic signed [WIDTH_B-1:0] coef [N+1];

  // Addresses beyond the last tap are dropped rather than aliased.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n <= N; n++) coef[n] <= '0;
    end else if (we && (waddr <= ADDR_MAX)) begin
      coef[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= ADDR_MAX) ? coef[raddr] : '0;

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed direct-form FIR: one multiplier and accumulator stepped over N+1 taps.
// Define FIR_MAC_SCHED_OVERLAP_EN to add an output register so a new sample overlaps the drain.
module fir_mac_sched import fir_pkg::*; #(
  parameter  int N       = 5,
  parameter  int WIDTH_X = 8,
  parameter  int WIDTH_B = 3,
  localparam int WIDTH_M = WIDTH_X + WIDTH_B,
  localparam int WIDTH_Y = fir_width_y(WIDTH_X, WIDTH_B, N),
  localparam int WIDTH_A = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [WIDTH_X-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [WIDTH_Y-1:0] m_data,
  input  logic                      coef_we,
  input  logic [WIDTH_A-1:0]        coef_addr,
  input  logic signed [WIDTH_B-1:0] coef_wdata,
  output logic                      busy
);

  localparam logic [WIDTH_A-1:0] K_LAST = WIDTH_A'(N);

  fir_state_t                state, state_nxt;
  logic [WIDTH_A-1:0]        k;
  logic signed [WIDTH_X-1:0] z [N+1];
  logic signed [WIDTH_Y-1:0] acc;
  logic signed [WIDTH_Y-1:0] acc_sum;
  logic signed [WIDTH_B-1:0] coef_k;
  logic signed [WIDTH_X-1:0] z_k;
  logic signed [WIDTH_M-1:0] prod_p0;
  logic                      accept;
  logic                      mac_last;
  logic                      coef_wr;

  assign s_ready  = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = s_valid && s_ready;
  assign mac_last = (state == MAC) && (k == K_LAST);
  assign coef_wr  = coef_we && (state == IDLE);

  fir_coef_rf #(
    .N       (N),
    .WIDTH_B (WIDTH_B)
  ) u_coef_rf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (coef_wr),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (k),
    .rdata (coef_k)
  );

  // Stage 0: full-precision product, exact in WIDTH_M bits.
  assign z_k     = z[k];
  assign prod_p0 = $signed({{WIDTH_X{coef_k[WIDTH_B-1]}}, coef_k})
                 * $signed({{WIDTH_B{z_k[WIDTH_X-1]}}, z_k});
  assign acc_sum = acc + $signed({{(WIDTH_Y - WIDTH_M){prod_p0[WIDTH_M-1]}}, prod_p0});

`ifdef FIR_MAC_SCHED_OVERLAP_EN
  logic signed [WIDTH_Y-1:0] res_p1;
  logic                      vld_p1;
  logic                      out_free;
  logic                      load_p1;

  assign out_free = !vld_p1 || m_ready;
  assign load_p1  = (mac_last || (state == OUT)) && out_free;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MAC;
`ifdef FIR_MAC_SCHED_OVERLAP_EN
      MAC:  if (mac_last) state_nxt = out_free ? IDLE : OUT;
      OUT:  if (out_free) state_nxt = IDLE;
`else
      MAC:  if (mac_last) state_nxt = OUT;
      OUT:  if (m_ready)  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line and accumulator; k wraps after the last tap so it never indexes past N.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n <= N; n++) z[n] <= '0;
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      for (int n = N; n > 0; n--) z[n] <= z[n-1];
      z[0] <= s_data;
      acc  <= '0;
      k    <= '0;
    end else if (state == MAC) begin
      acc <= acc_sum;
      k   <= mac_last ? '0 : k + 1'b1;
    end
  end

`ifdef FIR_MAC_SCHED_OVERLAP_EN
  // Stage 1: result register, loaded straight from the final sum or from a held acc.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (load_p1) begin
      vld_p1 <= 1'b1;
      res_p1 <= (state == OUT) ? acc : acc_sum;
    end else if (m_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = res_p1;
`else
  assign m_valid = (state == OUT);
  assign m_data  = acc;
`endif

endmodule
